icache_axi_rd_responder: RTL

Memory-side read responder for the instruction-cache refill interface: accepts a burst read request (address, length) from the cache and returns `len+1` 64-bit beats with `ready`/`last` strobes after a configurable access latency. Backed by an internal word array preloadable through a simple write port. Sits between the Icache refill port and main memory. It is also the bench memory model for cache verification.

---
 rtl/icache_axi_rd_responder_pkg.sv | 39 +++
 rtl/icache_axi_rd_responder_if.sv | 27 ++
 rtl/icache_axi_rd_mem.sv | 57 +++++
 rtl/icache_axi_rd_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/icache_axi_rd_responder_pkg.sv
// Shared definitions for the icache refill read responder.
//   - rd_state_e   : responder FSM states
//   - BEAT_W/LEN_W : beat data width, burst length field width
//   - ADDR_W/CNT_W : byte address width, latency/gap counter width
//   - addr_to_idx  : byte address -> 64-bit word index relative to the base
//   - below_base   : address lies under the mapped window
//   - idx_oor      : word index falls outside the backing array
package icache_axi_rd_responder_pkg;

  localparam int BEAT_W = 64;
  localparam int LEN_W  = 8;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BEAT  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  // Word index uses 32-bit unsigned wrap-around, so addresses under the base
  // land on very large indices rather than aliasing into the array.
  function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    return (addr - base) >> 3'd3;
  endfunction

  function automatic logic below_base(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base);
    return (addr < base);
  endfunction

  function automatic logic idx_oor(input logic [ADDR_W-1:0] idx,
                                   input logic [ADDR_W-1:0] words);
    return (idx >= words);
  endfunction

endpackage

// File: rtl/icache_axi_rd_responder_if.sv
// Refill request/response bus between the instruction cache and the responder.
//   req_valid/req_len/req_addr : burst request, held by the cache until done
//   rsp_ready/rsp_last/rsp_err : one-cycle beat strobes
//   rsp_data                   : beat data, holds between beats
// master = cache side, slave = responder side.
interface icache_axi_rd_responder_if;
  import icache_axi_rd_responder_pkg::*;

  logic              req_valid;
  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_ready;
  logic              rsp_last;
  logic [BEAT_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_len, req_addr,
    input  rsp_ready, rsp_last, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_len, req_addr,
    output rsp_ready, rsp_last, rsp_data, rsp_err
  );

endinterface

// File: rtl/icache_axi_rd_mem.sv
// Backing word array for the responder: synchronous write, asynchronous read.
//   clk      : clock
//   wr_en    : preload strobe; writes outside the window are dropped
//   wr_addr  : preload byte address
//   wr_data  : preload data
//   rd_idx   : word index to read (already relative to the base)
//   rd_data  : array word, or zero when rd_idx is out of range
//   rd_oor   : rd_idx lies outside the array
// A write and a read of the same word in one cycle return the old word,
// because the read is combinational and the write lands at the edge.
module icache_axi_rd_mem
  import icache_axi_rd_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [BEAT_W-1:0] rd_data,
  output logic              rd_oor
);

  localparam int                IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] WORDS_C = ADDR_W'(MEM_WORDS);

  logic [BEAT_W-1:0] mem_r [MEM_WORDS];

  logic [ADDR_W-1:0] wr_idx_s;
  logic              wr_oor_s;
  logic [IDX_W-1:0]  wr_slot_s;
  logic [IDX_W-1:0]  rd_slot_s;

  // Address decode for both ports and the range-checked read mux.
  always_comb begin
    wr_idx_s  = addr_to_idx(wr_addr, BASE_ADDR);
    wr_oor_s  = below_base(wr_addr, BASE_ADDR) | idx_oor(wr_idx_s, WORDS_C);
    wr_slot_s = wr_idx_s[IDX_W-1:0];
    rd_slot_s = rd_idx[IDX_W-1:0];
    rd_oor    = idx_oor(rd_idx, WORDS_C);
    if (rd_oor) begin
      rd_data = {BEAT_W{1'b0}};
    end else begin
      rd_data = mem_r[rd_slot_s];
    end
  end

  // Preload write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oor_s) begin
      mem_r[wr_slot_s] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_axi_rd_responder.sv
// Memory-side read responder for the instruction-cache refill port.
// Accepts a burst request and returns len+1 64-bit beats after LATENCY idle
// cycles, with BEAT_GAP idle cycles between beats.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : refill request/response bus (slave side)
//   wr_en      : preload write strobe
//   wr_addr    : preload byte address
//   wr_data    : preload data
//   beat_cnt   : total beats served since reset, wrapping
// Beats are issued at the clock edge, so a request captured at the end of
// cycle N shows its first beat in cycle N+1+LATENCY.
module icache_axi_rd_responder
  import icache_axi_rd_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                MEM_WORDS = 4096,
  parameter int                LATENCY   = 2,
  parameter int                BEAT_GAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  icache_axi_rd_responder_if.slave   bus,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [BEAT_W-1:0]          wr_data,
  output logic [31:0]                beat_cnt
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  // The cycle presenting a beat counts toward the gap countdown, hence +1.
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(BEAT_GAP + 1);
  localparam logic             NO_GAP_C = (BEAT_GAP == 0);

  rd_state_e         state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [LEN_W-1:0]  rem_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              below_r;
  logic              rsp_ready_r;
  logic              rsp_last_r;
  logic              rsp_err_r;
  logic [BEAT_W-1:0] rsp_data_r;
  logic [31:0]       beat_cnt_r;

  logic [ADDR_W-1:0] cap_idx_s;
  logic              cap_below_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic              rd_below_s;
  logic [LEN_W-1:0]  rd_rem_s;
  logic [BEAT_W-1:0] mem_data_s;
  logic              mem_oor_s;
  logic              beat_err_s;
  logic [BEAT_W-1:0] beat_data_s;
  logic              issue_s;

  icache_axi_rd_mem #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (rd_idx_s),
    .rd_data (mem_data_s),
    .rd_oor  (mem_oor_s)
  );

  // Beat source: with zero latency the first beat is issued on the capture
  // edge itself, so in IDLE the read comes straight from the request fields.
  always_comb begin
    cap_idx_s   = addr_to_idx(bus.req_addr, BASE_ADDR);
    cap_below_s = below_base(bus.req_addr, BASE_ADDR);
    if (state_r == ST_IDLE) begin
      rd_idx_s   = cap_idx_s;
      rd_below_s = cap_below_s;
      rd_rem_s   = bus.req_len;
    end else begin
      rd_idx_s   = idx_r;
      rd_below_s = below_r;
      rd_rem_s   = rem_r;
    end
  end

  // Beat payload and the decision to issue a beat at this edge.
  always_comb begin
    beat_err_s = mem_oor_s | rd_below_s;
    if (beat_err_s) begin
      beat_data_s = {BEAT_W{1'b0}};
    end else begin
      beat_data_s = mem_data_s;
    end
    case (state_r)
      ST_IDLE:  issue_s = bus.req_valid & (LAT_C == 4'd0);
      ST_WAIT:  issue_s = bus.req_valid & (cnt_r == 4'd1);
      ST_BEAT:  issue_s = bus.req_valid;
      ST_DRAIN: issue_s = 1'b0;
      default:  issue_s = 1'b0;
    endcase
  end

  // Responder FSM with registered beat outputs and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 32'd0;
      rem_r       <= 8'd0;
      cnt_r       <= 4'd0;
      below_r     <= 1'b0;
      rsp_ready_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {BEAT_W{1'b0}};
      beat_cnt_r  <= 32'd0;
    end else begin
      rsp_ready_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      if (issue_s) begin
        rsp_ready_r <= 1'b1;
        rsp_data_r  <= beat_data_s;
        rsp_err_r   <= beat_err_s;
        rsp_last_r  <= (rd_rem_s == 8'd0);
        beat_cnt_r  <= beat_cnt_r + 32'd1;
        below_r     <= rd_below_s;
        // Index keeps counting past the array end so trailing beats report errors.
        idx_r       <= rd_idx_s + 32'd1;
        if (rd_rem_s == 8'd0) begin
          state_r <= ST_DRAIN;
        end else begin
          rem_r <= rd_rem_s - 8'd1;
          if (NO_GAP_C) begin
            state_r <= ST_BEAT;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= GAP_C;
          end
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.req_valid) begin
              idx_r   <= cap_idx_s;
              below_r <= cap_below_s;
              rem_r   <= bus.req_len;
              cnt_r   <= LAT_C;
              state_r <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!bus.req_valid) begin
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          // Reaching here from BEAT means req_valid dropped: abort.
          ST_BEAT:  state_r <= ST_IDLE;
          // Hold off until the cache releases the finished request.
          ST_DRAIN: begin
            if (!bus.req_valid) begin
              state_r <= ST_IDLE;
            end
          end
          default:  state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rsp_ready = rsp_ready_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;
  assign beat_cnt      = beat_cnt_r;

endmodule
